// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: round-robin arbiter that shares one 16-bit left shifter
// (out = a << b) among NUM_REQ requesters. The tagged result is held in a
// one-entry output register until the consumer accepts it.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   req_valid     per-requester operand valid
//   req_ready     per-requester grant (combinational, one-hot or zero)
//   req_a, req_b  packed operands; requester i in bits [16i+15:16i]
//   resp_valid    result register full
//   resp_ready    consumer accepts the result
//   resp_data     shifted result
//   resp_id       index of the requester that produced resp_data
//   op_count      count of accepted requests, wraps at 16 bits
module shift_unit_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [15:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic [15:0]           op_count
);

  localparam int unsigned DW = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  logic            can_accept;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] scan_idx;
  logic            transfer;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic [DW-1:0]   shift_res;

  // Output register can take a new result when empty or draining this cycle.
  assign can_accept = (state_q == EMPTY) || resp_ready;

  // Round-robin search starting at ptr; index arithmetic wraps because
  // NUM_REQ is a power of two.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = ptr_q + ID_W'(i);
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Grant is suppressed while reset is held so no requester sees an accept.
  assign transfer  = grant_vld && can_accept && !rst;
  assign req_ready = transfer ? (NUM_REQ'(1) << grant_idx) : '0;

  // Shared datapath; Verilog shifts by >= 16 already yield zero.
  assign sel_a     = req_a[int'(grant_idx)*DW +: DW];
  assign sel_b     = req_b[int'(grant_idx)*DW +: DW];
  assign shift_res = sel_a << sel_b;

  // Output-register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a transfer refills, a drain without refill empties.
  always_comb begin
    state_d = state_q;
    if (transfer) begin
      state_d = FULL;
    end else if ((state_q == FULL) && resp_ready) begin
      state_d = EMPTY;
    end
  end

  assign resp_valid = (state_q == FULL);

  // Result, tag, round-robin pointer and operation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data <= '0;
      resp_id   <= '0;
      ptr_q     <= '0;
      op_count  <= '0;
    end else if (transfer) begin
      resp_data <= shift_res;
      resp_id   <= grant_idx;
      ptr_q     <= grant_idx + ID_W'(1);
      op_count  <= op_count + 16'd1;
    end
  end

endmodule

// File: doc/shift_unit_arbiter.md
# shift_unit_arbiter

Round-robin arbiter and sequencer that shares one 16-bit left-shift datapath (BitLeftShift16: out = a << b) among NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes the shift and holds the tagged result in a one-entry output register until the consumer accepts it. It sits between the accelerator's scalar issue ports and the shared shift resource.

## Interface
- NUM_REQ, 4, number of requesters; power of two, 2..8
- ID_W, 2, width of requester tag; equals log2(NUM_REQ)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester grant/accept; one-hot or zero
- req_a  in  16*NUM_REQ  operand a; requester i in bits [16i+15:16i]
- req_b  in  16*NUM_REQ  shift amount b; same packing
- resp_valid  out  1  result register full
- resp_ready  in  1  consumer accepts result
- resp_data  out  16  shifted result
- resp_id  out  ID_W  index of the requester that produced resp_data
- op_count  out  16  count of accepted requests; wraps

## Operation
- Output register states: EMPTY (resp_valid=0), FULL (resp_valid=1).
- can_accept = EMPTY, or FULL with resp_ready=1 (drain and refill in the same cycle).
- Grant: when can_accept, search req_valid starting at index ptr, wrapping upward. The first asserted index g gets req_ready[g]=1. All other bits are 0. All bits are 0 when nothing is valid or can_accept=0.
- req_ready is combinational from req_valid, ptr, resp_valid and resp_ready. Requesters must not make req_valid depend on req_ready.
- On a transfer (req_valid[g] & req_ready[g]) the block does the following at the clock edge:
  - resp_data <= req_a[g] << req_b[g], using all 16 bits of b; any b >= 16 yields 0x0000.
  - resp_id <= g
  - state goes to FULL
  - ptr <= (g+1) mod NUM_REQ
  - op_count <= op_count+1, wrapping 0xFFFF -> 0x0000.
- FULL with resp_ready=1 and no transfer: state goes to EMPTY. resp_data and resp_id keep their last values.
- FULL with resp_ready=0: resp_data, resp_id and ptr hold. No grants are issued.
- ptr changes only on a transfer. An idle cycle does not advance it.
- Requester holding rule: a requester keeps req_a/req_b stable while req_valid=1 and it is not granted. The block does not check this.

## Timing
- Reset (asynchronous, takes effect immediately, active while rst=1) sets:
  - state=EMPTY, resp_valid=0
  - resp_data=0x0000, resp_id=0
  - ptr=0, op_count=0x0000
  - req_ready=0 while rst=1.
- Latency: a transfer at edge N gives resp_valid=1 with the result after edge N.
- Throughput: one operation per cycle while resp_ready=1 is held.
- Fairness: under continuous contention from k requesters, each requester is granted once every k transfers.
- Reset asserted mid-operation discards any held result without a response. The next grant after reset release starts search at index 0.
- Simultaneous drain and transfer in FULL: the new result replaces the old one at the same edge, and resp_valid stays 1.

## Test plan
- Reset: assert rst asynchronously mid-cycle with random inputs. Required: resp_valid=0, resp_data=0, resp_id=0, op_count=0 and req_ready=0 immediately.
- Single request: requester 0 sends a=0x0001, b=0x0001, with resp_ready=1. Required: req_ready=0001 and next cycle resp_valid=1, resp_data=0x0002, resp_id=0. Then requester 2 sends a=0x0001, b=0x000F. Required: resp_data=0x8000, resp_id=2.
- Boundary shift: a=0xFFFF with b=0x0000 gives 0xFFFF. b=0x0010 gives 0x0000. b=0xFFFF gives 0x0000. a=0x0000 with b=0x0000 gives 0x0000.
- Contention: all four requesters hold valid continuously with resp_ready=1. Required: grants 0,1,2,3,0,1 on consecutive cycles, resp_id following the same sequence one cycle later, and op_count incrementing each cycle.
- Backpressure: load a result, then hold resp_ready=0 for 5 cycles with requester 1 valid. Required: resp_data/resp_id stable, req_ready=0 throughout. When resp_ready=1, requester 1 is granted that same cycle.
- Reset mid-operation and wrap: reset while FULL with other requesters pending. Required: resp_valid drops and the first post-reset grant goes to the lowest valid index. Separately, run 65536 transfers. Required: op_count wraps to 0x0000.
